// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: shares one memory port between instruction fetch and data.
// Data is preferred, but a bounded data streak keeps a waiting fetch from starving.
module core_bus_arbiter #(
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic        i_iReq,
   input  logic [31:0] i_iAddr,
   input  logic        i_dReq,
   input  logic        i_dWe,
   input  logic [31:0] i_dAddr,
   input  logic [31:0] i_dWData,
   input  logic [3:0]  i_dBe,
   output logic        o_mReq,
   output logic        o_mWe,
   output logic [31:0] o_mAddr,
   output logic [31:0] o_mWData,
   output logic [3:0]  o_mBe,
   input  logic        i_mAck,
   input  logic [31:0] i_mRData,
   output logic        o_iAck,
   output logic [31:0] o_iData,
   output logic        o_dAck,
   output logic [31:0] o_dData,
   output logic        o_BusErr
);

   localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
   localparam logic [7:0]    TO_LAST    = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic [7:0]    tmo_q, tmo_d;
   logic          owner_i_q, owner_i_d;
   logic          fetch_win, data_win;

   logic          m_req_d, m_we_d;
   logic [31:0]   m_addr_d, m_wdata_d;
   logic [3:0]    m_be_d;
   logic          i_ack_d, d_ack_d, bus_err_d;
   logic [31:0]   i_data_d, d_data_d;

   // Fetch wins only when alone or when the data streak has saturated.
   assign fetch_win = i_iReq && (!i_dReq || streak_q == STREAK_MAX);
   assign data_win  = i_dReq && !fetch_win;

   always_comb begin
      state_d   = state_q;
      streak_d  = streak_q;
      tmo_d     = tmo_q;
      owner_i_d = owner_i_q;
      m_req_d   = 1'b0;
      m_we_d    = o_mWe;
      m_addr_d  = o_mAddr;
      m_wdata_d = o_mWData;
      m_be_d    = o_mBe;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
      bus_err_d = 1'b0;
      i_data_d  = '0;
      d_data_d  = '0;
      unique case (state_q)
         IDLE: begin
            if (fetch_win || data_win) begin
               state_d   = BUSY;
               m_req_d   = 1'b1;
               tmo_d     = '0;
               owner_i_d = fetch_win;
               if (fetch_win) begin
                  m_we_d    = 1'b0;
                  m_addr_d  = i_iAddr;
                  m_wdata_d = '0;
                  m_be_d    = 4'hF;
                  streak_d  = '0;
               end else begin
                  m_we_d    = i_dWe;
                  m_addr_d  = i_dAddr;
                  m_wdata_d = i_dWData;
                  m_be_d    = i_dBe;
                  if (!i_iReq)
                     streak_d = '0;
                  else if (streak_q != STREAK_MAX)
                     streak_d = streak_q + 1'b1;
               end
            end
         end
         BUSY: begin
            m_req_d = 1'b1;
            // A late ack on the expiry cycle still counts as success.
            if (i_mAck || tmo_q == TO_LAST) begin
               state_d   = RESP;
               m_req_d   = 1'b0;
               bus_err_d = !i_mAck;
               i_ack_d   = owner_i_q;
               d_ack_d   = !owner_i_q;
               if (i_mAck && !o_mWe) begin
                  if (owner_i_q)
                     i_data_d = i_mRData;
                  else
                     d_data_d = i_mRData;
               end
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q   <= IDLE;
         streak_q  <= '0;
         tmo_q     <= '0;
         owner_i_q <= 1'b0;
         o_mReq    <= 1'b0;
         o_mWe     <= 1'b0;
         o_mAddr   <= '0;
         o_mWData  <= '0;
         o_mBe     <= '0;
         o_iAck    <= 1'b0;
         o_iData   <= '0;
         o_dAck    <= 1'b0;
         o_dData   <= '0;
         o_BusErr  <= 1'b0;
      end else begin
         state_q   <= state_d;
         streak_q  <= streak_d;
         tmo_q     <= tmo_d;
         owner_i_q <= owner_i_d;
         o_mReq    <= m_req_d;
         o_mWe     <= m_we_d;
         o_mAddr   <= m_addr_d;
         o_mWData  <= m_wdata_d;
         o_mBe     <= m_be_d;
         o_iAck    <= i_ack_d;
         o_iData   <= i_data_d;
         o_dAck    <= d_ack_d;
         o_dData   <= d_data_d;
         o_BusErr  <= bus_err_d;
      end
   end

endmodule
